// File: rtl/mac_seg_tx_drain.sv
// mac_seg_tx_drain: pops packet words from the 8-deep flop FIFO and forwards
// them onto a registered valid/ready TX interface. Packets are framed by the
// sop/eop bits carried in each word; a start is held off until START_THRESH
// words are buffered (or the head word is a single-word packet), and IPG idle
// cycles are forced after each eop pop. Words reaching IDLE without sop are
// dropped and flagged on err_nosop.
// Optional: define MAC_SEG_TX_DRAIN_STATS_EN to add pkt_cnt / stall_cnt.
module mac_seg_tx_drain #(
    parameter int DW           = 64,
    parameter int START_THRESH = 2,
    parameter int IPG          = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW+1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic [3:0]    fifo_cnt,
    output logic          fifo_pop,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [DW-1:0] tx_data,
    output logic          tx_sop,
    output logic          tx_eop,
    output logic          err_nosop
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
    ,
    output logic [31:0]   pkt_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [3:0] THRESH4 = 4'(START_THRESH);
    localparam logic [3:0] IPG4    = 4'(IPG);

    typedef struct packed {
        logic          eop;
        logic          sop;
        logic [DW-1:0] data;
    } word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_GAP
    } state_t;

    state_t     state;
    logic [3:0] gap_cnt;
    word_t      head;
    logic       slot_free;
    logic       can_pop;
    logic       drop;
    logic       load;
    logic       end_pkt;

    assign head      = fifo_dout;
    assign slot_free = !tx_valid | tx_ready;

    // Which states may pop the head word; IDLE gates packet starts on fill level
    always_comb begin
        can_pop = 1'b0;
        case (state)
            S_IDLE:  can_pop = !head.sop | (fifo_cnt >= THRESH4) | head.eop;
            S_XFER:  can_pop = 1'b1;
            default: can_pop = 1'b0;
        endcase
    end

    // Pop is suppressed during reset so the FIFO never loses a word to us then
    assign fifo_pop = !reset & can_pop & !fifo_empty & slot_free;
    assign drop     = fifo_pop & (state == S_IDLE) & !head.sop;
    assign load     = fifo_pop & !drop;
    assign end_pkt  = load & head.eop;

    // Framing FSM; the gap counter starts at the eop pop, not its handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            gap_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_XFER: begin
                    if (end_pkt) begin
                        if (IPG4 != 4'd0) begin
                            state   <= S_GAP;
                            gap_cnt <= IPG4;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (load) begin
                        state <= S_XFER;
                    end
                end
                S_GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        state   <= S_IDLE;
                        gap_cnt <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    gap_cnt <= 4'd0;
                end
            endcase
        end
    end

    // TX output register: load on pop, clear valid on handshake, else hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= head.data;
            tx_sop   <= head.sop;
            tx_eop   <= head.eop;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    // One-cycle flag for a sop-less word discarded in IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_nosop <= 1'b0;
        else       err_nosop <= drop;
    end

`ifdef MAC_SEG_TX_DRAIN_STATS_EN
    // Packet counter (wrapping) and back-pressure cycle counter (saturating)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt   <= 32'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (tx_valid & tx_ready & tx_eop)
                pkt_cnt <= pkt_cnt + 32'd1;
            if (tx_valid & !tx_ready & (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mac_seg_tx_drain.sv
// Bench for mac_seg_tx_drain: a queue-backed FIFO model feeds the DUT, a
// packet-level reference (built as words are pushed) predicts the accepted
// word stream and dropped-word count, and a negedge monitor checks the
// handshake stream, back-pressure hold, gap and start-threshold rules.
module tb_mac_seg_tx_drain;
    localparam int DW     = 64;
    localparam int THRESH = 2;
    localparam int IPG    = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW+1:0] fifo_dout;
    logic          fifo_empty;
    logic [3:0]    fifo_cnt;
    logic          fifo_pop;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_sop;
    logic          tx_eop;
    logic          err_nosop;
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [15:0]   stall_cnt;
`endif

    mac_seg_tx_drain #(.DW(DW), .START_THRESH(THRESH), .IPG(IPG)) dut (
        .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_cnt(fifo_cnt), .fifo_pop(fifo_pop), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .err_nosop(err_nosop)
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
        , .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW+1:0] fq[$];      // FIFO contents, head at index 0
    logic [DW+1:0] exp_q[$];   // words the MAC is expected to accept, in order
    int            exp_err;    // sop-less words expected to be dropped
    bit            mdl_in_pkt;
    bit            mon_en;

    function automatic logic [DW+1:0] mkw(input logic s, input logic e, input logic [DW-1:0] d);
        return {e, s, d};
    endfunction

    // Reference: a word outside a packet without sop is dropped, anything else is forwarded
    task automatic push_word(input logic [DW+1:0] w);
        fq.push_back(w);
        if (!mdl_in_pkt && !w[DW]) begin
            exp_err++;
        end else begin
            exp_q.push_back(w);
            mdl_in_pkt = !w[DW+1];
        end
    endtask

    // FIFO model: pop on the edge, present the new head shortly after
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fq.delete();
            fifo_dout  = '0;
            fifo_empty = 1'b1;
            fifo_cnt   = 4'd0;
        end else begin
            if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
            #2;
            fifo_empty = (fq.size() == 0);
            fifo_cnt   = 4'(fq.size());
            fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
        end
    end

    // Monitor: rule checks that hold on every cycle
    logic [DW+1:0] prev_word;
    logic [DW+1:0] e;
    bit            prev_stall;
    bit            mon_in_pkt;
    int            gap_left;
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            prev_stall = 0;
            mon_in_pkt = 0;
            gap_left   = 0;
        end else begin
            checks++;
            if (fifo_pop && fifo_empty) begin
                failures++;
                $display("FAIL pop_while_empty fifo_pop=%0b fifo_empty=%0b t=%0t", fifo_pop, fifo_empty, $time);
            end
            if (gap_left > 0) begin
                checks++;
                if (fifo_pop !== 1'b0) begin
                    failures++;
                    $display("FAIL ipg_gap fifo_pop=%0b required=0 t=%0t", fifo_pop, $time);
                end
                gap_left--;
            end
            if (tx_valid && !tx_ready) begin
                checks++;
                if (fifo_pop !== 1'b0) begin
                    failures++;
                    $display("FAIL backpressure_pop fifo_pop=%0b required=0 t=%0t", fifo_pop, $time);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({tx_valid, tx_eop, tx_sop, tx_data} !== {1'b1, prev_word}) begin
                    failures++;
                    $display("FAIL stall_hold got=%0b/%0h required=1/%0h t=%0t", tx_valid,
                             {tx_eop, tx_sop, tx_data}, prev_word, $time);
                end
            end
            if (fifo_pop) begin
                if (!mon_in_pkt && fifo_dout[DW]) begin
                    checks++;
                    if (!(fifo_cnt >= THRESH || fifo_dout[DW+1])) begin
                        failures++;
                        $display("FAIL start_thresh cnt=%0d required>=%0d t=%0t", fifo_cnt, THRESH, $time);
                    end
                end
                if (mon_in_pkt || fifo_dout[DW]) begin
                    mon_in_pkt = !fifo_dout[DW+1];
                    if (fifo_dout[DW+1]) gap_left = IPG;
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word got=%0h required=none t=%0t", {tx_eop, tx_sop, tx_data}, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_eop, tx_sop, tx_data} !== e) begin
                        failures++;
                        $display("FAIL tx_word got=%0h required=%0h t=%0t", {tx_eop, tx_sop, tx_data}, e, $time);
                    end
                end
            end
            if (err_nosop) begin
                checks++;
                if (exp_err == 0) begin
                    failures++;
                    $display("FAIL unexpected_err err_nosop=1 required=0 t=%0t", $time);
                end else begin
                    exp_err--;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_word  = {tx_eop, tx_sop, tx_data};
        end
    end

    task automatic test_reset();
        reset    = 1'b1;
        tx_ready = 1'b0;
        mon_en   = 0;
        exp_err  = 0;
        mdl_in_pkt = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_valid, tx_sop, tx_eop, err_nosop, fifo_pop} !== 5'b0 || tx_data !== '0) begin
            failures++;
            $display("FAIL reset_state got=%0b%0b%0b%0b%0b data=%0h required=0", tx_valid, tx_sop,
                     tx_eop, err_nosop, fifo_pop, tx_data);
        end
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
        checks++;
        if (pkt_cnt !== 32'd0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_stats pkt=%0d stall=%0d required=0/0", pkt_cnt, stall_cnt);
        end
`endif
        #1 reset = 1'b0;
        tx_ready = 1'b1;
        mon_en   = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_packet();
        bit exp_pop[6] = '{1, 1, 1, 1, 0, 0};
        bit exp_vld[6] = '{0, 1, 1, 1, 1, 0};
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
        logic [31:0] p0;
        p0 = pkt_cnt;
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_word(mkw(i == 0, i == 3, 64'(8'hA0 + i)));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== exp_pop[i] || tx_valid !== exp_vld[i]) begin
                failures++;
                $display("FAIL basic_timing cyc=%0d pop/vld=%0b%0b required=%0b%0b", i, fifo_pop,
                         tx_valid, exp_pop[i], exp_vld[i]);
            end
            if (i >= 1 && i <= 4) begin
                checks++;
                if ({tx_eop, tx_sop, tx_data} !== mkw(i == 1, i == 4, 64'(8'hA0 + i - 1))) begin
                    failures++;
                    $display("FAIL basic_word cyc=%0d got=%0h required=%0h", i, {tx_eop, tx_sop, tx_data},
                             mkw(i == 1, i == 4, 64'(8'hA0 + i - 1)));
                end
            end
        end
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
        checks++;
        if (pkt_cnt - p0 !== 32'd1) begin
            failures++;
            $display("FAIL pkt_cnt delta=%0d required=1", pkt_cnt - p0);
        end
`endif
    endtask

    task automatic test_single_word();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        push_word(mkw(1, 1, 64'h55));
        @(negedge clk);
        checks++;
        if (fifo_pop !== 1'b1) begin
            failures++;
            $display("FAIL single_pop fifo_pop=%0b required=1", fifo_pop);
        end
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_sop, tx_eop} !== 3'b111 || tx_data !== 64'h55) begin
            failures++;
            $display("FAIL single_out vld/sop/eop=%0b%0b%0b data=%0h required=111/55", tx_valid, tx_sop,
                     tx_eop, tx_data);
        end
    endtask

    task automatic test_threshold_bubble();
        bit exp_pop[5] = '{1, 1, 0, 0, 0};
        bit exp_vld[5] = '{0, 1, 1, 0, 0};
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        push_word(mkw(1, 0, 64'hB0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== 1'b0) begin
                failures++;
                $display("FAIL thresh_hold cyc=%0d fifo_pop=%0b required=0", i, fifo_pop);
            end
        end
        @(posedge clk); #1;
        push_word(mkw(0, 0, 64'hB1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== exp_pop[i] || tx_valid !== exp_vld[i]) begin
                failures++;
                $display("FAIL bubble cyc=%0d pop/vld=%0b%0b required=%0b%0b", i, fifo_pop, tx_valid,
                         exp_pop[i], exp_vld[i]);
            end
        end
        @(posedge clk); #1;
        push_word(mkw(0, 1, 64'hB2));
        @(negedge clk);
        checks++;
        if (fifo_pop !== 1'b1) begin
            failures++;
            $display("FAIL bubble_resume fifo_pop=%0b required=1", fifo_pop);
        end
        @(negedge clk);
        checks++;
        if ({tx_valid, tx_eop} !== 2'b11 || tx_data !== 64'hB2) begin
            failures++;
            $display("FAIL bubble_last vld/eop=%0b%0b data=%0h required=11/b2", tx_valid, tx_eop, tx_data);
        end
    endtask

    task automatic test_back_to_back();
        bit exp_pop[4] = '{1, 0, 1, 0};
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        push_word(mkw(1, 1, 64'h61));
        push_word(mkw(1, 1, 64'h62));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_pop !== exp_pop[i]) begin
                failures++;
                $display("FAIL b2b_gap cyc=%0d fifo_pop=%0b required=%0b", i, fifo_pop, exp_pop[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW+2:0] held;
        int n;
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
        logic [15:0] s0;
`endif
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_word(mkw(i == 0, i == 2, 64'(8'hC0 + i)));
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (!tx_valid) begin
            failures++;
            $display("FAIL bp_timeout tx_valid=0 required=1");
        end
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                held = {tx_valid, tx_eop, tx_sop, tx_data};
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
                s0 = stall_cnt;
`endif
            end
            checks++;
            if (fifo_pop !== 1'b0 || {tx_valid, tx_eop, tx_sop, tx_data} !== held || !tx_valid) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d pop=%0b word=%0h required=0/%0h", i, fifo_pop,
                         {tx_valid, tx_eop, tx_sop, tx_data}, held);
            end
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
`ifdef MAC_SEG_TX_DRAIN_STATS_EN
        checks++;
        if (stall_cnt - s0 !== 16'd5) begin
            failures++;
            $display("FAIL stall_cnt delta=%0d required=5", stall_cnt - s0);
        end
`endif
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nosop_drop();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        push_word(mkw(0, 0, 64'hD0));
        push_word(mkw(1, 0, 64'hD1));
        push_word(mkw(0, 1, 64'hD2));
        @(negedge clk);
        checks++;
        if (fifo_pop !== 1'b1 || err_nosop !== 1'b0) begin
            failures++;
            $display("FAIL nosop_pop pop/err=%0b%0b required=10", fifo_pop, err_nosop);
        end
        @(negedge clk);
        checks++;
        if (err_nosop !== 1'b1 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL nosop_err err/vld=%0b%0b required=10", err_nosop, tx_valid);
        end
        @(negedge clk);
        checks++;
        if (err_nosop !== 1'b0 || tx_valid !== 1'b1 || tx_sop !== 1'b1 || tx_data !== 64'hD1) begin
            failures++;
            $display("FAIL nosop_next err/vld/sop=%0b%0b%0b data=%0h required=011/d1", err_nosop,
                     tx_valid, tx_sop, tx_data);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        int n;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_word(mkw(i == 0, i == 3, 64'(8'hE0 + i)));
        n = 0;
        @(negedge clk);
        while (!(tx_valid && tx_data == 64'hE1) && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (!(tx_valid && tx_data == 64'hE1)) begin
            failures++;
            $display("FAIL rst_wait data=%0h required=e1", tx_data);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || fifo_pop !== 1'b0) begin
            failures++;
            $display("FAIL rst_async vld/pop=%0b%0b required=00", tx_valid, fifo_pop);
        end
        exp_q.delete();
        exp_err    = 0;
        mdl_in_pkt = 0;
        @(negedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_word(mkw(0, 0, 64'hE2));
        push_word(mkw(0, 1, 64'hE3));
        push_word(mkw(1, 0, 64'hF0));
        push_word(mkw(0, 1, 64'hF1));
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (tx_valid !== 1'b1 || tx_sop !== 1'b1 || tx_data !== 64'hF0) begin
            failures++;
            $display("FAIL rst_first vld/sop=%0b%0b data=%0h required=11/f0", tx_valid, tx_sop, tx_data);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [DW+1:0] pending[$];
        int len;
        int cyc;
        while (pending.size() < 300) begin
            if ($urandom % 8 == 0) pending.push_back(mkw(0, 1'($urandom % 2), {$urandom, $urandom}));
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++)
                pending.push_back(mkw((i == 0) || ($urandom % 6 == 0), i == len - 1, {$urandom, $urandom}));
        end
        cyc = 0;
        while (cyc < 5000 && (pending.size() > 0 || exp_q.size() > 0 || fq.size() > 0 || exp_err > 0)) begin
            @(posedge clk); #1;
            tx_ready = (pending.size() == 0) ? 1'b1 : 1'(($urandom % 10) < 7);
            if (pending.size() > 0 && fq.size() < 7 && ($urandom % 4) != 0)
                push_word(pending.pop_front());
            cyc++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || exp_err != 0 || pending.size() != 0) begin
            failures++;
            $display("FAIL random_drain left_words=%0d left_errs=%0d required=0/0", exp_q.size(), exp_err);
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_single_word();
        test_threshold_bubble();
        test_back_to_back();
        test_backpressure();
        test_nosop_drop();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
